// File: rtl/vec_wb_buffer.sv
// Writeback buffer in front of the vector register file write port: an in-order
// FIFO of {addr,data} results with pending-write hazard lookup on two read addresses.
module vec_wb_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  wb_stall,
  input  logic                  flush,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] chk_addr_1,
  input  logic [ADDR_WIDTH-1:0] chk_addr_2,
  output logic                  hazard_1,
  output logic                  hazard_2,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign full     = (count == CNT_WIDTH'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready && !flush;

  // The head is presented for the whole cycle so the register file's negedge
  // write samples settled values; wb_stall is flop-driven and equally stable.
  assign wr_en = !empty && !wb_stall && !flush;
  assign waddr = mem_addr[rd_ptr];
  assign wdata = mem_data[rd_ptr];
  assign pop   = wr_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  // NOTE: entry storage is deliberately not reset; count gates every reader, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Only the count entries starting at rd_ptr are live; slots beyond them hold stale results.
  always_comb begin
    // NOTE: defaults before the loop keep this block purely combinational (no latches).
    hazard_1 = 1'b0;
    hazard_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_WIDTH'(i) < count) begin
        if (mem_addr[rd_ptr + PTR_WIDTH'(i)] == chk_addr_1) hazard_1 = 1'b1;
        if (mem_addr[rd_ptr + PTR_WIDTH'(i)] == chk_addr_2) hazard_2 = 1'b1;
      end
    end
  end

endmodule
